// File: rtl/mux_n_1_flops_arb_if.sv
// ---------------------------------------------------------------------------
// mux_n_1_flops_arb_if
//   Bundle of the producer/consumer signals around the N:1 registered
//   multiplexer. The slave modport is the mux itself; the master modport is
//   whatever drives the producers and the consumer.
//
//   mode       0 = explicit selector, 1 = round-robin arbitration
//   selector   channel index used when mode = 0
//   data_in    packed producer words, channel i at [i*WIDTH +: WIDTH]
//   valid_in   per-channel data-valid
//   grant      one-hot, bit i high in the cycle channel i is captured
//   data_out   registered output word
//   valid_out  registered output valid
//   sel_out    registered index of the channel held in data_out
//   ready_out  consumer accepts data_out when valid_out && ready_out
// ---------------------------------------------------------------------------
interface mux_n_1_flops_arb_if #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);

  logic                      mode;
  logic [SEL_W-1:0]          selector;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [CHANNELS-1:0]       valid_in;
  logic [CHANNELS-1:0]       grant;
  logic [WIDTH-1:0]          data_out;
  logic                      valid_out;
  logic [SEL_W-1:0]          sel_out;
  logic                      ready_out;

  modport master (
    output mode,
    output selector,
    output data_in,
    output valid_in,
    output ready_out,
    input  grant,
    input  data_out,
    input  valid_out,
    input  sel_out
  );

  modport slave (
    input  mode,
    input  selector,
    input  data_in,
    input  valid_in,
    input  ready_out,
    output grant,
    output data_out,
    output valid_out,
    output sel_out
  );

endinterface

// File: rtl/mux_n_1_flops_arb.sv
// ---------------------------------------------------------------------------
// mux_n_1_flops_arb
//   Parametrised N:1 registered multiplexer with per-channel valids, output
//   valid/ready backpressure and a runtime choice between an explicit
//   selector and round-robin arbitration. The winning producer sees a
//   combinational one-hot grant in the cycle its word is captured; the word
//   appears on data_out one cycle later.
//
//   clk    rising-edge clock
//   reset  synchronous, active-high; dominates every other input
//   bus    mux_n_1_flops_arb_if.slave (see the interface for signal list)
//
//   Parameters: WIDTH bits per channel, CHANNELS inputs (>= 2),
//   SEL_W index width with 2**SEL_W >= CHANNELS.
// ---------------------------------------------------------------------------
module mux_n_1_flops_arb #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  mux_n_1_flops_arb_if.slave      bus
);

  // CHANNELS always fits in SEL_W+1 bits because 2**SEL_W >= CHANNELS.
  localparam logic [SEL_W:0]   CH_COUNT = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);

  // Registered state.
  logic [WIDTH-1:0]          data_q;
  logic                      valid_q;
  logic [SEL_W-1:0]          sel_q;
  logic [SEL_W-1:0]          ptr_q;   // round-robin start point, always < CHANNELS

  // Decision logic.
  logic                      free;
  logic [CHANNELS-1:0]       sel_onehot;
  logic                      sel_hit;
  logic [2*CHANNELS-1:0]     valid_dbl;
  logic [CHANNELS-1:0]       valid_rot;
  logic                      rr_hit;
  logic [SEL_W:0]            rr_sum;
  logic [SEL_W-1:0]          rr_ch;
  logic                      cand_hit;
  logic [SEL_W-1:0]          cand_ch;
  logic                      capture;
  logic [CHANNELS-1:0]       grant_vec;
  logic [WIDTH-1:0]          data_pick;
  logic [SEL_W-1:0]          ptr_next;

  // The output slot can take a new word when it is empty or being drained
  // this very cycle, which gives back-to-back streaming.
  assign free = !valid_q || bus.ready_out;

  // Explicit selection: an out-of-range selector matches no channel, so it
  // can never produce a grant.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    sel_onehot = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_onehot[i] = (bus.selector == SEL_W'(i));
    end
    sel_hit = |(bus.valid_in & sel_onehot);
  end

  // Round-robin: rotate the valids so that bit k of valid_rot is channel
  // (ptr + k) mod CHANNELS, take the lowest set bit, then map it back to an
  // absolute channel index with a single conditional subtract.
  always_comb begin
    valid_dbl = {bus.valid_in, bus.valid_in};
    valid_rot = CHANNELS'(valid_dbl >> ptr_q);
    rr_hit    = 1'b0;
    rr_sum    = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!rr_hit && valid_rot[k]) begin
        rr_hit = 1'b1;
        rr_sum = {1'b0, ptr_q} + (SEL_W+1)'(k);
      end
    end
    rr_ch = (rr_sum >= CH_COUNT) ? SEL_W'(rr_sum - CH_COUNT) : SEL_W'(rr_sum);
  end

  // Mode only steers which candidate is considered; it never touches state.
  assign cand_hit = bus.mode ? rr_hit : sel_hit;
  assign cand_ch  = bus.mode ? rr_ch  : bus.selector;

  // Reset suppresses the grant in its own cycle so a producer never believes
  // a word was taken that the reset is about to discard.
  assign capture  = free && cand_hit && !reset;

  always_comb begin
    grant_vec = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      grant_vec[i] = capture && (cand_ch == SEL_W'(i));
    end
  end

  // AND-OR mux driven by the one-hot grant; avoids a variable part-select.
  always_comb begin
    data_pick = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_vec[i]) begin
        data_pick = data_pick | bus.data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign ptr_next = (cand_ch == LAST_CH) ? '0 : cand_ch + SEL_W'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else if (free) begin
      if (capture) begin
        data_q  <= data_pick;
        valid_q <= 1'b1;
        sel_q   <= cand_ch;
        if (bus.mode) begin
          ptr_q <= ptr_next;
        end
      end else begin
        // Slot drained (or already empty) with nothing to refill it: drop
        // valid but leave the last word and index visible.
        valid_q <= 1'b0;
      end
    end
    // Not free: the held word is stalled and every register keeps its value.
  end

  assign bus.grant     = grant_vec;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.sel_out   = sel_q;

endmodule

// File: tb/tb_mux_n_1_flops_arb.sv
// ---------------------------------------------------------------------------
// tb_mux_n_1_flops_arb
//   Self-checking bench for mux_n_1_flops_arb (WIDTH=2, CHANNELS=4, SEL_W=3
//   so that out-of-range selectors can be driven). A table of hand-derived
//   cycles covers reset, explicit select, round-robin order, skip/wrap,
//   backpressure, mode alternation and mid-transfer reset; random cycles are
//   then checked against a behavioural model of the selection rules.
// ---------------------------------------------------------------------------
module tb_mux_n_1_flops_arb;

  localparam int WIDTH    = 2;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 3;

  // Channel words: ch0=01, ch1=10, ch2=11, ch3=00.
  localparam logic [CHANNELS*WIDTH-1:0] D = 8'b00_11_10_01;

  typedef struct {
    logic                      rst;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] data;
    logic [CHANNELS-1:0]       valid;
    logic                      ready;
    logic [CHANNELS-1:0]       exp_grant;
    logic                      exp_valid;
    logic [WIDTH-1:0]          exp_data;
    logic [SEL_W-1:0]          exp_sel;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  mux_n_1_flops_arb_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) bus ();

  mux_n_1_flops_arb #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state.
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_data  = '0;
  int               m_sel   = 0;
  int               m_ptr   = 0;

  vec_t tbl[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  function automatic bit bit_at(logic [CHANNELS-1:0] v, int i);
    logic [CHANNELS-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // Channel the rules say is captured this cycle, or -1 for none.
  function automatic int model_pick();
    int sel;
    if (reset) return -1;
    if (m_valid && !bus.ready_out) return -1;
    if (!bus.mode) begin
      sel = int'(bus.selector);
      if (sel < CHANNELS && bit_at(bus.valid_in, sel)) return sel;
      return -1;
    end
    for (int k = 0; k < CHANNELS; k++) begin
      if (bit_at(bus.valid_in, (m_ptr + k) % CHANNELS)) return (m_ptr + k) % CHANNELS;
    end
    return -1;
  endfunction

  function automatic void add(logic rst, logic mode, int sel, logic [CHANNELS-1:0] valid,
                              logic ready, logic [CHANNELS-1:0] eg, logic ev, int ed, int es);
    vec_t v;
    v.rst = rst; v.mode = mode; v.sel = SEL_W'(sel); v.data = D; v.valid = valid;
    v.ready = ready; v.exp_grant = eg; v.exp_valid = ev;
    v.exp_data = WIDTH'(ed); v.exp_sel = SEL_W'(es);
    tbl.push_back(v);
  endfunction

  // One clock cycle: drive, check the combinational grant mid-cycle, advance
  // the model on the edge, then check the registered outputs just after it.
  task automatic step(string tag, logic use_tbl, vec_t v);
    int                        pick;
    logic [CHANNELS-1:0]       eg;
    logic [CHANNELS*WIDTH-1:0] t;
    reset         = v.rst;
    bus.mode      = v.mode;
    bus.selector  = v.sel;
    bus.data_in   = v.data;
    bus.valid_in  = v.valid;
    bus.ready_out = v.ready;
    @(negedge clk);
    pick = model_pick();
    eg   = '0;
    if (pick >= 0) eg = CHANNELS'(1) << pick;
    check({tag, " grant"}, 32'(bus.grant), 32'(use_tbl ? v.exp_grant : eg));
    if (!use_tbl) check({tag, " onehot"}, 32'($countones(bus.grant) > 1), 32'(0));
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    end else if (!m_valid || bus.ready_out) begin
      if (pick >= 0) begin
        t       = bus.data_in >> (pick * WIDTH);
        m_data  = t[WIDTH-1:0];
        m_valid = 1'b1;
        m_sel   = pick;
        if (bus.mode) m_ptr = (pick + 1) % CHANNELS;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check({tag, " valid_out"}, 32'(bus.valid_out), 32'(use_tbl ? v.exp_valid : m_valid));
    check({tag, " data_out"},  32'(bus.data_out),  32'(use_tbl ? v.exp_data  : m_data));
    check({tag, " sel_out"},   32'(bus.sel_out),   32'(use_tbl ? v.exp_sel   : SEL_W'(m_sel)));
  endtask

  initial begin
    vec_t r;

    //  rst mode sel valid   rdy  grant   v  d  s
    // Reset with every channel valid, then round-robin from channel 0.
    add(1, 1, 0, 4'b1111, 1, 4'b0000, 0, 0, 0);
    add(1, 1, 0, 4'b1111, 1, 4'b0000, 0, 0, 0);
    add(0, 1, 0, 4'b1111, 1, 4'b0001, 1, 1, 0);
    add(0, 1, 0, 4'b1111, 1, 4'b0010, 1, 2, 1);
    add(0, 1, 0, 4'b1111, 1, 4'b0100, 1, 3, 2);
    add(0, 1, 0, 4'b1111, 1, 4'b1000, 1, 0, 3);
    add(0, 1, 0, 4'b1111, 1, 4'b0001, 1, 1, 0);
    add(0, 1, 0, 4'b1111, 1, 4'b0010, 1, 2, 1);
    add(0, 1, 0, 4'b1111, 1, 4'b0100, 1, 3, 2);
    add(0, 1, 0, 4'b1111, 1, 4'b1000, 1, 0, 3);
    // Park ptr at 3, then skip and wrap over channels 0 and 2.
    add(0, 1, 0, 4'b0100, 1, 4'b0100, 1, 3, 2);
    add(0, 1, 0, 4'b0101, 1, 4'b0001, 1, 1, 0);
    add(0, 1, 0, 4'b0101, 1, 4'b0100, 1, 3, 2);
    add(0, 1, 0, 4'b0101, 1, 4'b0001, 1, 1, 0);
    // Explicit select of channel 2, then an out-of-range selector.
    add(0, 0, 2, 4'b0100, 1, 4'b0100, 1, 3, 2);
    add(0, 0, 5, 4'b0100, 1, 4'b0000, 0, 3, 2);
    // Load channel 0, stall three cycles, then release (ptr is 1).
    add(0, 0, 0, 4'b1111, 1, 4'b0001, 1, 1, 0);
    add(0, 1, 0, 4'b1111, 0, 4'b0000, 1, 1, 0);
    add(0, 1, 0, 4'b1111, 0, 4'b0000, 1, 1, 0);
    add(0, 1, 0, 4'b1111, 0, 4'b0000, 1, 1, 0);
    add(0, 1, 0, 4'b1111, 1, 4'b0010, 1, 2, 1);
    // Alternate mode with selector=1; ptr only moves in mode=1 cycles.
    add(0, 0, 1, 4'b1111, 1, 4'b0010, 1, 2, 1);
    add(0, 1, 1, 4'b1111, 1, 4'b0100, 1, 3, 2);
    add(0, 0, 1, 4'b1111, 1, 4'b0010, 1, 2, 1);
    add(0, 1, 1, 4'b1111, 1, 4'b1000, 1, 0, 3);
    add(0, 0, 1, 4'b1111, 1, 4'b0010, 1, 2, 1);
    add(0, 1, 1, 4'b1111, 1, 4'b0001, 1, 1, 0);
    // Stall, reset while stalled, then restart from channel 0.
    add(0, 1, 1, 4'b1111, 0, 4'b0000, 1, 1, 0);
    add(1, 1, 1, 4'b1111, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 0, 4'b1111, 1, 4'b0001, 1, 1, 0);
    // Free slot with no candidate; then capture into an empty slot with ready low.
    add(0, 1, 0, 4'b0000, 1, 4'b0000, 0, 1, 0);
    add(0, 1, 0, 4'b0100, 0, 4'b0100, 1, 3, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("tbl%0d", i), 1'b1, tbl[i]);
    end

    for (int i = 0; i < 400; i++) begin
      r.rst   = ($urandom_range(0, 49) == 0);
      r.mode  = 1'($urandom_range(0, 1));
      r.sel   = SEL_W'($urandom_range(0, 7));
      r.data  = (CHANNELS*WIDTH)'($urandom);
      r.valid = CHANNELS'($urandom);
      r.ready = ($urandom_range(0, 3) != 0);
      r.exp_grant = '0; r.exp_valid = 1'b0; r.exp_data = '0; r.exp_sel = '0;
      step($sformatf("rnd%0d", i), 1'b0, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
